avst_symbol_downsizer: RTL

Parametrised Avalon-ST data format adapter that splits each wide input beat of IN_SYMBOLS symbols into IN_SYMBOLS/OUT_SYMBOLS narrower output beats of OUT_SYMBOLS symbols each. It carries channel, error, packet framing and empty across the split. It sits between a wide-datapath pixel/sample producer and a narrower streaming sink, for example 24-bit RGB to an 8-bit LCD or 64-bit FFT output to a 16-bit DAC path. It generalises the fixed 24-to-8 adapter with configurable symbol width, ratio, channel and error fields and with a multi-symbol output empty.

---
 rtl/avst_symbol_downsizer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/avst_symbol_downsizer.sv
// avst_symbol_downsizer: splits IN_SYMBOLS-wide Avalon-ST beats (in_* sink) into OUT_SYMBOLS-wide beats (out_* source), carrying channel/error/SOP/EOP/empty
module avst_symbol_downsizer #(
  parameter int SYMBOL_W = 8,
  parameter int IN_SYMBOLS = 3,
  parameter int OUT_SYMBOLS = 1,
  parameter int CHANNEL_W = 1,
  parameter int ERROR_W = 1,
  localparam int IN_EMPTY_W = IN_SYMBOLS > 1 ? $clog2(IN_SYMBOLS) : 1,
  localparam int OUT_EMPTY_W = OUT_SYMBOLS > 1 ? $clog2(OUT_SYMBOLS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic                            in_ready,
  input  logic                            in_valid,
  input  logic [IN_SYMBOLS*SYMBOL_W-1:0]  in_data,
  input  logic [CHANNEL_W-1:0]            in_channel,
  input  logic [ERROR_W-1:0]              in_error,
  input  logic                            in_startofpacket,
  input  logic                            in_endofpacket,
  input  logic [IN_EMPTY_W-1:0]           in_empty,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [OUT_SYMBOLS*SYMBOL_W-1:0] out_data,
  output logic [CHANNEL_W-1:0]            out_channel,
  output logic [ERROR_W-1:0]              out_error,
  output logic                            out_startofpacket,
  output logic                            out_endofpacket,
  output logic [OUT_EMPTY_W-1:0]          out_empty
);
  localparam int RATIO = IN_SYMBOLS / OUT_SYMBOLS;
  localparam int IN_W = IN_SYMBOLS * SYMBOL_W;
  localparam int OUT_W = OUT_SYMBOLS * SYMBOL_W;
  localparam int SLICE_W = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int CW = $clog2(IN_SYMBOLS + OUT_SYMBOLS) + 1;

  logic                   a_valid_q, a_valid_d, a_sop_q, a_sop_d, a_eop_q, a_eop_d;
  logic [IN_W-1:0]        a_data_q, a_data_d;
  logic [CHANNEL_W-1:0]   a_ch_q, a_ch_d, och_q, och_d;
  logic [ERROR_W-1:0]     a_err_q, a_err_d, oerr_q, oerr_d;
  logic [IN_EMPTY_W-1:0]  a_empty_q, a_empty_d;
  logic [SLICE_W-1:0]     slice_q, slice_d, last;
  logic                   ov_q, ov_d, osop_q, osop_d, oeop_q, oeop_d;
  logic [OUT_W-1:0]       od_q, od_d;
  logic [OUT_EMPTY_W-1:0] oemp_q, oemp_d;
  logic [CW-1:0]          nsym, nslices;
  logic                   is_last, b_ready, accept, xfer;

  always_comb begin
    nsym = CW'(IN_SYMBOLS) - CW'(a_empty_q);
    nslices = (nsym + CW'(OUT_SYMBOLS - 1)) / CW'(OUT_SYMBOLS);
    last = a_eop_q ? SLICE_W'(nslices - CW'(1)) : SLICE_W'(RATIO - 1);
    is_last = slice_q == last;
    b_ready = out_ready || !ov_q;
    in_ready = !a_valid_q || (b_ready && is_last);
    accept = in_valid && in_ready;
    xfer = b_ready && a_valid_q;
    a_valid_d = accept || (a_valid_q && !(xfer && is_last));
    a_data_d = accept ? in_data : a_data_q;
    a_ch_d = accept ? in_channel : a_ch_q;
    a_err_d = accept ? in_error : a_err_q;
    a_sop_d = accept ? in_startofpacket : a_sop_q;
    a_eop_d = accept ? in_endofpacket : a_eop_q;
    a_empty_d = !accept ? a_empty_q :
                !in_endofpacket ? '0 :
                32'(in_empty) >= IN_SYMBOLS ? IN_EMPTY_W'(IN_SYMBOLS - 1) : in_empty;
    slice_d = !xfer ? slice_q : is_last ? '0 : slice_q + SLICE_W'(1);
    ov_d = b_ready ? a_valid_q : ov_q;
    od_d = b_ready ? OUT_W'(a_data_q >> ((RATIO - 1 - 32'(slice_q)) * OUT_W)) : od_q;
    och_d = b_ready ? a_ch_q : och_q;
    oerr_d = b_ready ? a_err_q : oerr_q;
    osop_d = b_ready ? a_sop_q && slice_q == '0 : osop_q;
    oeop_d = b_ready ? a_eop_q && is_last : oeop_q;
    oemp_d = !b_ready ? oemp_q :
             a_eop_q && is_last ? OUT_EMPTY_W'(nslices * CW'(OUT_SYMBOLS) - nsym) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      a_data_q <= '0;
      a_ch_q <= '0;
      a_err_q <= '0;
      a_sop_q <= 1'b0;
      a_eop_q <= 1'b0;
      a_empty_q <= '0;
      slice_q <= '0;
      ov_q <= 1'b0;
      od_q <= '0;
      och_q <= '0;
      oerr_q <= '0;
      osop_q <= 1'b0;
      oeop_q <= 1'b0;
      oemp_q <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q <= a_data_d;
      a_ch_q <= a_ch_d;
      a_err_q <= a_err_d;
      a_sop_q <= a_sop_d;
      a_eop_q <= a_eop_d;
      a_empty_q <= a_empty_d;
      slice_q <= slice_d;
      ov_q <= ov_d;
      od_q <= od_d;
      och_q <= och_d;
      oerr_q <= oerr_d;
      osop_q <= osop_d;
      oeop_q <= oeop_d;
      oemp_q <= oemp_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data = od_q;
  assign out_channel = och_q;
  assign out_error = oerr_q;
  assign out_startofpacket = osop_q;
  assign out_endofpacket = oeop_q;
  assign out_empty = oemp_q;
endmodule
